// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared types and helpers for the two-port line memory arbiter.
//               This package holds the arbiter FSM state encoding, the width
//               of the write wait counter, and a saturating increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam int unsigned c_WAIT_CNT_W = 4;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [c_WAIT_CNT_W-1:0] sat_inc(input logic [c_WAIT_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker.
// Ports       : valid_i[1:0]  request lines (bit N = port N)
//               last_i        port that won most recently
//               winner_o      selected port (meaningful only when any_o)
//               any_o         at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       winner_o,
  output logic       any_o
);

  always_comb begin
    any_o = |valid_i;
    // On contention the port that did not win last time goes next;
    // otherwise the single requester wins.
    if (&valid_i) begin
      winner_o = ~last_i;
    end else begin
      winner_o = valid_i[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates a D-cache (port 0) and an I-cache (port 1) onto a
//               single line-wide data memory. One transaction at a time:
//               IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ports       : clk, reset             clock, async active-high reset
//               reqN_valid/write/addr/wdata   per-port request (N = 0, 1)
//               reqN_gnt/done/rdata    per-port ownership, completion, fill data
//               mem_is_input_valid     one-cycle request strobe to memory
//               mem_addr/read/write/din latched request to memory
//               mem_is_output_valid, mem_dout  read return from memory
//               mem_ready              memory can accept a request
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_SIZE = 16,
  parameter int unsigned MEM_AW    = 32 - $clog2(LINE_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic                   req0_write,
  input  logic [31:0]            req0_addr,
  input  logic [LINE_SIZE*8-1:0] req0_wdata,
  output logic                   req0_gnt,
  output logic                   req0_done,
  output logic [LINE_SIZE*8-1:0] req0_rdata,
  input  logic                   req1_valid,
  input  logic                   req1_write,
  input  logic [31:0]            req1_addr,
  input  logic [LINE_SIZE*8-1:0] req1_wdata,
  output logic                   req1_gnt,
  output logic                   req1_done,
  output logic [LINE_SIZE*8-1:0] req1_rdata,
  output logic                   mem_is_input_valid,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] mem_dout,
  input  logic                   mem_ready
);

  localparam int unsigned c_LW    = LINE_SIZE * 8;
  localparam int unsigned c_OFS_W = $clog2(LINE_SIZE);

  arb_state_e              state_q;
  logic                    last_q;       // last granted port
  logic                    write_q;      // latched operation
  logic [MEM_AW-1:0]       line_addr_q;  // latched line address
  logic [c_LW-1:0]         wdata_q;      // latched write-back data
  logic [c_LW-1:0]         rdata_q;      // captured fill data
  logic [c_WAIT_CNT_W-1:0] cnt_q;        // WAIT cycles elapsed
  logic [c_WAIT_CNT_W-1:0] cnt_d;
  logic [1:0]              gnt_q;
  logic [1:0]              done_q;
  logic                    strobe_q;
  logic                    rd_q;
  logic                    wr_q;

  logic                    w_winner;
  logic                    w_any;
  logic                    w_sel_write;
  logic [31:0]             w_sel_addr;
  logic [c_LW-1:0]         w_sel_wdata;

  rr_pick2 u_pick (
    .valid_i  ({req1_valid, req0_valid}),
    .last_i   (last_q),
    .winner_o (w_winner),
    .any_o    (w_any)
  );

  assign w_sel_write = w_winner ? req1_write : req0_write;
  assign w_sel_addr  = w_winner ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_winner ? req1_wdata : req0_wdata;
  assign cnt_d       = sat_inc(cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      write_q     <= 1'b0;
      line_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      strobe_q    <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
    end else begin
      // Strobe, op select and done are single-cycle pulses.
      strobe_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      done_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (mem_ready && w_any) begin
            last_q      <= w_winner;
            write_q     <= w_sel_write;
            line_addr_q <= MEM_AW'(w_sel_addr >> c_OFS_W);
            wdata_q     <= w_sel_wdata;
            gnt_q       <= w_winner ? 2'b10 : 2'b01;
            // Memory strobe is registered so it lines up with ISSUE.
            strobe_q    <= 1'b1;
            rd_q        <= ~w_sel_write;
            wr_q        <= w_sel_write;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (!write_q && mem_is_output_valid) begin
            rdata_q <= mem_dout;
            done_q  <= gnt_q;
            state_q <= ST_RESP;
          end else if (write_q && mem_ready && (cnt_q != '0)) begin
            // mem_ready may still be high in the first WAIT cycle from before
            // the memory registered the strobe, so it is not trusted there.
            done_q  <= gnt_q;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_gnt           = gnt_q[0];
  assign req1_gnt           = gnt_q[1];
  assign req0_done          = done_q[0];
  assign req1_done          = done_q[1];
  assign req0_rdata         = (done_q[0] && !write_q) ? rdata_q : '0;
  assign req1_rdata         = (done_q[1] && !write_q) ? rdata_q : '0;
  assign mem_is_input_valid = strobe_q;
  assign mem_read           = rd_q;
  assign mem_write          = wr_q;
  assign mem_addr           = line_addr_q;
  assign mem_din            = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus a
//               randomized run against a cycle-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LS = 16;
  localparam int LW = 128;
  localparam int AW = 28;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     v, w;
  logic [31:0]    a  [2];
  logic [LW-1:0]  wd [2];
  logic           g0, g1, d0, d1;
  logic [LW-1:0]  rd0, rd1;
  logic           strobe, mrd, mwr;
  logic [AW-1:0]  maddr;
  logic [LW-1:0]  mdin;
  logic           mvalid, mready;
  logic [LW-1:0]  mdout;
  logic [4+2*LW+1+AW+2+LW-1:0] all_outs;

  assign all_outs = {g0, g1, d0, d1, rd0, rd1, strobe, maddr, mrd, mwr, mdin};

  mem_arbiter #(.LINE_SIZE(LS), .MEM_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_write(w[0]), .req0_addr(a[0]), .req0_wdata(wd[0]),
    .req0_gnt(g0), .req0_done(d0), .req0_rdata(rd0),
    .req1_valid(v[1]), .req1_write(w[1]), .req1_addr(a[1]), .req1_wdata(wd[1]),
    .req1_gnt(g1), .req1_done(d1), .req1_rdata(rd1),
    .mem_is_input_valid(strobe), .mem_addr(maddr), .mem_read(mrd), .mem_write(mwr),
    .mem_din(mdin), .mem_is_output_valid(mvalid), .mem_dout(mdout), .mem_ready(mready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Memory environment knobs/state
  int lat_fix   = -1;
  int ready_pct = 100;
  bit mem_busy, mem_rd, rearm;
  int mem_cnt;
  logic [LW-1:0] last_dout;

  // Monitor records
  int            n_strobe;
  int            st_cyc  [$];
  logic [AW-1:0] st_addr [$];
  bit            st_rd   [$];
  bit            st_wr   [$];
  logic [LW-1:0] st_din  [$];
  logic [1:0]    st_gnt  [$];
  int            dn_cyc  [$];
  int            n_done  [2];
  int            done_cyc[2];
  logic [LW-1:0] done_rd [2];
  int            n_gnt   [2];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_mon();
    n_strobe = 0;
    st_cyc.delete(); st_addr.delete(); st_rd.delete(); st_wr.delete();
    st_din.delete(); st_gnt.delete(); dn_cyc.delete();
    for (int p = 0; p < 2; p++) begin
      n_done[p] = 0; done_cyc[p] = -1; done_rd[p] = '0; n_gnt[p] = 0;
    end
  endtask

  // Called at the negedge of the current cycle: record outputs, retire
  // completed requests and drive the memory's inputs for this cycle.
  task automatic prep();
    if (strobe) begin
      n_strobe++;
      st_cyc.push_back(cyc); st_addr.push_back(maddr); st_rd.push_back(mrd);
      st_wr.push_back(mwr); st_din.push_back(mdin); st_gnt.push_back({g1, g0});
    end
    if (g0) n_gnt[0]++;
    if (g1) n_gnt[1]++;
    if (d0) begin n_done[0]++; done_cyc[0] = cyc; done_rd[0] = rd0; dn_cyc.push_back(cyc); if (!rearm) v[0] = 1'b0; end
    if (d1) begin n_done[1]++; done_cyc[1] = cyc; done_rd[1] = rd1; dn_cyc.push_back(cyc); if (!rearm) v[1] = 1'b0; end
    if (strobe) begin
      mem_busy = 1'b1; mem_rd = mrd;
      mem_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 5));
      mvalid = 1'b0; mready = 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt > 0) begin
        mem_cnt--; mvalid = 1'b0; mready = 1'b0;
      end else if (mem_rd) begin
        mvalid = 1'b1; mdout = {$urandom, $urandom, $urandom, $urandom};
        last_dout = mdout; mready = 1'b0; mem_busy = 1'b0;
      end else begin
        mvalid = 1'b0; mready = 1'b1; mem_busy = 1'b0;
      end
    end else begin
      mvalid = 1'b0;
      mready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; v = '0; w = '0; mvalid = 1'b0; mready = 1'b1;
    mem_busy = 1'b0; rearm = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin prep(); tick(); end
  endtask

  task automatic test_reset();
    reset = 1'b1; v = '0; w = '0; mvalid = 1'b0; mready = 1'b1; mdout = '0;
    a[0] = '0; a[1] = '0; wd[0] = '0; wd[1] = '0;
    @(negedge clk);
    tick();
    checks++; if (all_outs !== '0) begin failures++; $display("FAIL reset_outs: got %h want 0", all_outs); end
    reset = 1'b0;
    clear_mon();
    run(3);
    checks++; if (all_outs !== '0) begin failures++; $display("FAIL idle_outs: got %h want 0", all_outs); end
    checks++; if (n_gnt[0] + n_gnt[1] + n_strobe != 0) begin failures++; $display("FAIL idle_activity: got %0d want 0", n_gnt[0] + n_gnt[1] + n_strobe); end
  endtask

  task automatic test_single_read();
    int t0;
    do_reset(); clear_mon(); lat_fix = 4; ready_pct = 100;
    t0 = cyc; v[1] = 1'b1; w[1] = 1'b0; a[1] = 32'h0000_0120; wd[1] = {4{$urandom}};
    run(20);
    checks++; if (n_strobe != 1) begin failures++; $display("FAIL rd_strobes: got %0d want 1", n_strobe); end
    if (n_strobe >= 1) begin
      checks++; if (st_cyc[0] != t0 + 1) begin failures++; $display("FAIL rd_strobe_cyc: got %0d want %0d", st_cyc[0], t0 + 1); end
      checks++; if (st_addr[0] !== 28'h12) begin failures++; $display("FAIL rd_addr: got %h want 12", st_addr[0]); end
      checks++; if ({st_rd[0], st_wr[0]} !== 2'b10) begin failures++; $display("FAIL rd_op: got %b want 10", {st_rd[0], st_wr[0]}); end
      checks++; if (st_gnt[0] !== 2'b10) begin failures++; $display("FAIL rd_gnt: got %b want 10", st_gnt[0]); end
    end
    checks++; if (n_done[1] != 1 || n_done[0] != 0) begin failures++; $display("FAIL rd_done_cnt: got %0d/%0d want 1/0", n_done[1], n_done[0]); end
    checks++; if (done_cyc[1] != t0 + 7) begin failures++; $display("FAIL rd_latency: got %0d want %0d", done_cyc[1] - t0, 7); end
    checks++; if (done_rd[1] !== last_dout) begin failures++; $display("FAIL rd_data: got %h want %h", done_rd[1], last_dout); end
  endtask

  task automatic test_contention();
    do_reset(); clear_mon(); lat_fix = -1; ready_pct = 100; rearm = 1'b1;
    v = 2'b11; w[0] = 1'b0; w[1] = 1'b1;
    a[0] = $urandom; a[1] = $urandom; wd[1] = {4{$urandom}};
    for (int i = 0; i < 80 && n_strobe < 4; i++) begin prep(); tick(); end
    rearm = 1'b0; v = '0;
    run(20);
    checks++; if (n_strobe < 4) begin failures++; $display("FAIL cont_strobes: got %0d want >=4", n_strobe); end
    if (n_strobe >= 4 && dn_cyc.size() >= 1) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (st_gnt[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          failures++; $display("FAIL cont_order%0d: got %b want %b", k, st_gnt[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      checks++; if ({st_rd[0], st_wr[1]} !== 2'b11) begin failures++; $display("FAIL cont_ops: got %b want 11", {st_rd[0], st_wr[1]}); end
      checks++; if (st_addr[1] !== AW'(a[1] / LS)) begin failures++; $display("FAIL cont_addr1: got %h want %h", st_addr[1], AW'(a[1] / LS)); end
      checks++; if (st_cyc[1] != dn_cyc[0] + 2) begin failures++; $display("FAIL cont_gap: got %0d want %0d", st_cyc[1], dn_cyc[0] + 2); end
    end
  endtask

  task automatic test_write(input int wl);
    int t0;
    logic [LW-1:0] data;
    data = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    do_reset(); clear_mon(); lat_fix = wl; ready_pct = 100;
    t0 = cyc; v[0] = 1'b1; w[0] = 1'b1; a[0] = 32'h0000_0040; wd[0] = data;
    run(20);
    checks++; if (n_strobe != 1) begin failures++; $display("FAIL wr_strobes: got %0d want 1", n_strobe); end
    if (n_strobe >= 1) begin
      checks++; if ({st_rd[0], st_wr[0]} !== 2'b01) begin failures++; $display("FAIL wr_op: got %b want 01", {st_rd[0], st_wr[0]}); end
      checks++; if (st_din[0] !== data) begin failures++; $display("FAIL wr_din: got %h want %h", st_din[0], data); end
      checks++; if (st_addr[0] !== 28'h4) begin failures++; $display("FAIL wr_addr: got %h want 4", st_addr[0]); end
    end
    checks++; if (n_done[0] != 1) begin failures++; $display("FAIL wr_done_cnt: got %0d want 1", n_done[0]); end
    checks++;
    if (done_cyc[0] != t0 + 3 + ((wl < 1) ? 1 : wl)) begin
      failures++; $display("FAIL wr_latency: got %0d want %0d", done_cyc[0] - t0, 3 + ((wl < 1) ? 1 : wl));
    end
  endtask

  task automatic test_ready_block();
    int t1;
    do_reset(); clear_mon(); lat_fix = 1; ready_pct = 0; mready = 1'b0;
    v[0] = 1'b1; w[0] = 1'b0; a[0] = $urandom;
    run(8);
    checks++; if (n_strobe != 0 || n_gnt[0] != 0) begin failures++; $display("FAIL blk_grant: got %0d/%0d want 0/0", n_strobe, n_gnt[0]); end
    ready_pct = 100; t1 = cyc;
    run(12);
    checks++; if (n_strobe != 1) begin failures++; $display("FAIL blk_strobes: got %0d want 1", n_strobe); end
    if (n_strobe >= 1) begin
      checks++; if (st_cyc[0] != t1 + 1) begin failures++; $display("FAIL blk_strobe_cyc: got %0d want %0d", st_cyc[0], t1 + 1); end
    end
    checks++; if (n_done[0] != 1) begin failures++; $display("FAIL blk_done: got %0d want 1", n_done[0]); end
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset(); clear_mon(); lat_fix = 6; ready_pct = 100;
    v[1] = 1'b1; w[1] = 1'b0; a[1] = $urandom;
    run(4);
    checks++; if (g1 !== 1'b1) begin failures++; $display("FAIL rst_mid_gnt: got %b want 1", g1); end
    reset = 1'b1;
    #1;
    checks++; if (all_outs !== '0) begin failures++; $display("FAIL rst_mid_outs: got %h want 0", all_outs); end
    v = '0; mem_busy = 1'b0; mvalid = 1'b0; mready = 1'b1;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    clear_mon();
    run(12);
    checks++; if (n_done[0] + n_done[1] + n_strobe != 0) begin failures++; $display("FAIL rst_mid_abort: got %0d want 0", n_done[0] + n_done[1] + n_strobe); end
    lat_fix = 1; t0 = cyc; v[0] = 1'b1; w[0] = 1'b0; a[0] = $urandom;
    run(12);
    checks++; if (n_done[0] != 1 || done_cyc[0] != t0 + 4) begin failures++; $display("FAIL rst_mid_next: got %0d@%0d want 1@%0d", n_done[0], done_cyc[0], t0 + 4); end
  endtask

  task automatic test_drop();
    int t0;
    do_reset(); clear_mon(); lat_fix = 3; ready_pct = 100;
    t0 = cyc; v[1] = 1'b1; w[1] = 1'b0; a[1] = $urandom;
    run(3);
    v[1] = 1'b0;
    run(15);
    checks++; if (n_done[1] != 1) begin failures++; $display("FAIL drop_done_cnt: got %0d want 1", n_done[1]); end
    checks++; if (done_cyc[1] != t0 + 6) begin failures++; $display("FAIL drop_done_cyc: got %0d want %0d", done_cyc[1], t0 + 6); end
    checks++; if ({g1, n_strobe == 1} !== 2'b01) begin failures++; $display("FAIL drop_idle: got gnt=%b strobes=%0d want 0/1", g1, n_strobe); end
  endtask

  // Reference: one transaction at a time, decided in an idle cycle, strobe the
  // cycle after, completion rule applied from the second cycle after decision.
  task automatic test_random(input int ncyc);
    int m_own, m_t, m_done, win;
    bit m_last, m_write;
    logic [31:0] m_a;
    logic [LW-1:0] m_wdata, m_rdata, r;
    logic [1:0] e_gnt, e_done, busy_p;
    logic e_strobe;
    do_reset(); clear_mon(); lat_fix = -1; ready_pct = 80;
    m_own = -1; m_last = 1'b1; m_t = 0; m_done = -1; m_write = 1'b0;
    m_a = '0; m_wdata = '0; m_rdata = '0; busy_p = '0;
    for (int i = 0; i < ncyc; i++) begin
      e_gnt = '0; e_done = '0; e_strobe = 1'b0;
      if (m_own >= 0) begin
        if (cyc > m_t && (m_done < 0 || cyc <= m_done)) e_gnt[m_own] = 1'b1;
        if (cyc == m_t + 1) e_strobe = 1'b1;
        if (cyc == m_done) e_done[m_own] = 1'b1;
      end
      checks++; if ({g1, g0} !== e_gnt) begin failures++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, {g1, g0}, e_gnt); end
      checks++; if ({d1, d0} !== e_done) begin failures++; $display("FAIL rnd_done@%0d: got %b want %b", cyc, {d1, d0}, e_done); end
      checks++; if (strobe !== e_strobe) begin failures++; $display("FAIL rnd_strobe@%0d: got %b want %b", cyc, strobe, e_strobe); end
      if (e_strobe) begin
        checks++;
        if ({maddr, mrd, mwr, mdin} !== {AW'(m_a / LS), ~m_write, m_write, m_wdata}) begin
          failures++; $display("FAIL rnd_memreq@%0d: got %h %b%b %h want %h %b%b %h", cyc, maddr, mrd, mwr, mdin,
                               AW'(m_a / LS), ~m_write, m_write, m_wdata);
        end
      end
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? rd0 : rd1;
        if (e_done[p] && !m_write) begin
          checks++; if (r !== m_rdata) begin failures++; $display("FAIL rnd_rdata%0d@%0d: got %h want %h", p, cyc, r, m_rdata); end
        end else if (!e_gnt[p]) begin
          checks++; if (r !== '0) begin failures++; $display("FAIL rnd_rdata_idle%0d@%0d: got %h want 0", p, cyc, r); end
        end
      end
      if (d0) busy_p[0] = 1'b0;
      if (d1) busy_p[1] = 1'b0;
      prep();
      for (int p = 0; p < 2; p++) begin
        if (!busy_p[p] && $urandom_range(0, 2) == 0) begin
          busy_p[p] = 1'b1; v[p] = 1'b1; w[p] = 1'($urandom_range(0, 1));
          a[p] = $urandom; wd[p] = {$urandom, $urandom, $urandom, $urandom};
        end else if (m_own == p && cyc > m_t + 1 && v[p] && $urandom_range(0, 7) == 0) begin
          v[p] = 1'b0;
        end
      end
      if (m_own >= 0 && cyc == m_done) begin
        m_own = -1;
      end else if (m_own < 0) begin
        if (mready && (v[0] || v[1])) begin
          if (v[0] && v[1]) win = m_last ? 0 : 1;
          else              win = v[0] ? 0 : 1;
          m_last = (win == 1); m_own = win; m_t = cyc; m_done = -1;
          m_write = w[win]; m_a = a[win]; m_wdata = wd[win];
        end
      end else if (cyc >= m_t + 2 && m_done < 0) begin
        if (!m_write && mvalid) begin
          m_rdata = mdout; m_done = cyc + 1;
        end else if (m_write && cyc >= m_t + 3 && mready) begin
          m_done = cyc + 1;
        end
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mon();
    test_reset();
    test_single_read();
    test_contention();
    test_write(3);
    test_write(0);
    test_ready_block();
    test_reset_mid();
    test_drop();
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_SIZE, default 16, means cache line size in bytes; line data width = LINE_SIZE*8 (LW).
REQ-002 Parameter MEM_AW, default 32-CLOG2(LINE_SIZE), means memory-side line-address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 reqN_valid  in  1  (N=0,1; 0=D-cache, 1=I-cache) request pending; held until reqN_done.
REQ-006 reqN_write  in  1  1=line write-back, 0=line fill read.
REQ-007 reqN_addr  in  32  byte address of line.
REQ-008 reqN_wdata  in  LW  write-back line data.
REQ-009 reqN_gnt  out  1  port N owns memory (ISSUE through RESP).
REQ-010 reqN_done  out  1  one-cycle completion pulse.
REQ-011 reqN_rdata  out  LW  fill data, valid only while reqN_done and read.
REQ-012 mem_is_input_valid  out  1  one-cycle request strobe to data memory.
REQ-013 mem_addr  out  MEM_AW  line address = latched addr >> CLOG2(LINE_SIZE).
REQ-014 mem_read / mem_write  out  1 each  operation select, exactly one high when strobing.
REQ-015 mem_din  out  LW  latched write data.
REQ-016 mem_is_output_valid  in  1  read data valid.
REQ-017 mem_dout  in  LW  read data.
REQ-018 mem_ready  in  1  memory can accept a request; low while busy.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; exactly one state active.
REQ-020 IDLE: if mem_ready and any reqN_valid, pick winner, latch addr/write/wdata/id, go ISSUE next cycle; else stay.
REQ-021 Arbitration round-robin: both valid -> port other than last_grant wins; one valid -> that port wins.
REQ-022 last_grant updates on latch; reset value 1, so port 0 wins first contention.
REQ-023 ISSUE: mem_is_input_valid=1 for exactly this one cycle with mem_addr/mem_read/mem_write/mem_din from latches; go WAIT.
REQ-024 WAIT read: on mem_is_output_valid capture mem_dout into rdata register, go RESP.
REQ-025 WAIT write: first cycle in WAIT with mem_ready=1 and wait counter >= 1 ends write, go RESP; counter (4 bits, saturating) counts WAIT cycles.
REQ-026 RESP: granted port's reqN_done=1 and reqN_rdata=captured data for one cycle; go IDLE.
REQ-027 Minimum request-to-done latency = 3 cycles + memory latency; back-to-back grants separated by at least one IDLE cycle.
REQ-028 Loser's valid held unchanged through winner's transaction; served on next IDLE.
REQ-029 reqN_valid dropping mid-transaction is ignored; transaction completes and done still pulses.
REQ-030 Inputs of non-granted port never reach memory outputs; mem outputs are latched values, not live inputs.
REQ-031 mem_ready low in IDLE blocks grant regardless of requests.
REQ-032 Non-granted port: gnt=0, done=0, rdata=0.

Reset
REQ-033 reset asserted anytime, including mid-WAIT: state=IDLE, all outputs 0, latches 0, counter 0, last_grant=1, immediately (async).
REQ-034 An aborted transaction produces no done pulse; first grant may occur the first posedge after reset deasserts.

Structure
REQ-035 State encodings (2-bit) in shared header arbstates.v alongside cache state defines; CLOG2.v reused.
REQ-036 One sub-module rr_pick2 (combinational 2-way round-robin: valid[1:0], last -> winner, any).

Verification
REQ-037 Single read port1 addr 0x0000_0120, memory latency 4 -> mem_addr=0x12, mem_read=1, req1_done at cycle 3+4, rdata=mem_dout.
REQ-038 Simultaneous req0 read and req1 write after reset -> port0 first, port1 granted on next IDLE; alternates on repeated contention.
REQ-039 Write port0 data 0xDEAD..BEEF addr 0x40 -> mem_write=1, mem_din matches, done when mem_ready returns, one strobe only.
REQ-040 reset pulsed during WAIT -> all outputs 0 same cycle, no done pulse, next request served normally.
REQ-041 mem_ready held low with req0 valid -> no gnt, no strobe until mem_ready=1.
REQ-042 req1 drops valid in WAIT -> req1_done still pulses once, then IDLE.
